compress_pack_engine: RTL

COMPRESS_PACK_ENGINE -- requirements
Module: compress_pack_engine

---
 rtl/compress_pack_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/compress_pack_engine.sv
// Compresses ML-KEM coefficients to d bits, packs them LSB-first into DATA_WIDTH
// words and either writes them to the API or compares them against API read data.
module compress_pack_engine #(
    parameter int COEFF_PER_CLK = 4,
    parameter int COEFF_W       = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_W        = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             zeroize,
    input  logic                             start,
    input  logic [3:0]                       d_sel,
    input  logic                             compare_mode,
    input  logic [2:0]                       num_poly,
    input  logic [ADDR_W-1:0]                dest_base_addr,
    input  logic                             coeff_valid,
    output logic                             coeff_ready,
    input  logic [COEFF_PER_CLK*COEFF_W-1:0] coeff_data,
    output logic                             api_wr_en,
    output logic                             api_rd_en,
    output logic [ADDR_W-1:0]                api_addr,
    output logic [DATA_WIDTH-1:0]            api_wr_data,
    input  logic [DATA_WIDTH-1:0]            api_rd_data,
    output logic                             busy,
    output logic                             done,
    output logic                             cmp_fail,
    output logic [ADDR_W-1:0]                cmp_fail_addr,
    output logic                             cfg_err
);
    localparam int ACC_W  = DATA_WIDTH + COEFF_PER_CLK*12;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int NEW_W  = COEFF_PER_CLK*12;
    localparam int BEAT_W = 12;
    localparam int PROD_W = COEFF_W + 13;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [3:0]          d_q;
    logic                cmp_mode_q;
    logic [ACC_W-1:0]    acc;
    logic [FILL_W-1:0]   fill;
    logic [BEAT_W-1:0]   beats_left;
    logic [ADDR_W-1:0]   addr_ptr;
    logic                tail;
    logic                cmp_pending;
    logic [DATA_WIDTH-1:0] cmp_word;
    logic [ADDR_W-1:0]   cmp_addr;

    logic [NEW_W-1:0]    new_bits;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   quot;
    logic [11:0]         y;

    // Per-lane rounding compression, packed so lane 0 lands in the lowest bits.
    always_comb begin
        new_bits = '0;
        prod     = '0;
        quot     = '0;
        y        = '0;
        for (int i = 0; i < COEFF_PER_CLK; i++) begin
            prod = PROD_W'(coeff_data[i*COEFF_W +: COEFF_W]) << d_q;
            quot = (prod + PROD_W'(1664)) / PROD_W'(3329);
            if (d_q == 4'd12)
                y = 12'(coeff_data[i*COEFF_W +: COEFF_W]);
            else
                y = 12'(quot) & ((12'd1 << d_q) - 12'd1);
            new_bits = new_bits | (NEW_W'(y) << (i * int'(d_q)));
        end
    end

    logic                accept;
    logic                pop;
    logic [FILL_W-1:0]   step;
    logic [FILL_W-1:0]   fill_after_pop;
    logic [FILL_W-1:0]   fill_next;
    logic [FILL_W-1:0]   post_next;
    logic [ACC_W-1:0]    acc_next;
    logic [BEAT_W-1:0]   beats_next;
    logic                room_next;
    logic                cfg_legal;

    always_comb begin
        accept         = coeff_valid && coeff_ready;
        pop            = (state == RUN || state == DRAIN) && (fill >= FILL_W'(DATA_WIDTH));
        step           = FILL_W'(COEFF_PER_CLK) * FILL_W'(d_q);
        fill_after_pop = pop ? fill - FILL_W'(DATA_WIDTH) : fill;
        acc_next       = (pop ? acc >> DATA_WIDTH : acc)
                         | (accept ? (ACC_W'(new_bits) << fill_after_pop) : '0);
        fill_next      = fill_after_pop + (accept ? step : '0);
        beats_next     = beats_left - (accept ? BEAT_W'(1) : '0);
        post_next      = (fill_next >= FILL_W'(DATA_WIDTH)) ? fill_next - FILL_W'(DATA_WIDTH) : fill_next;
        room_next      = (int'(post_next) + int'(step)) <= ACC_W;
        cfg_legal      = (d_sel >= 4'd1) && (d_sel <= 4'd12) && (num_poly != 3'd0);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            state         <= IDLE;
            d_q           <= '0;
            cmp_mode_q    <= 1'b0;
            acc           <= '0;
            fill          <= '0;
            beats_left    <= '0;
            addr_ptr      <= '0;
            tail          <= 1'b0;
            cmp_pending   <= 1'b0;
            cmp_word      <= '0;
            cmp_addr      <= '0;
            coeff_ready   <= 1'b0;
            api_wr_en     <= 1'b0;
            api_rd_en     <= 1'b0;
            api_addr      <= '0;
            api_wr_data   <= '0;
            done          <= 1'b0;
            cmp_fail      <= 1'b0;
            cmp_fail_addr <= '0;
            cfg_err       <= 1'b0;
        end else begin
            api_wr_en   <= 1'b0;
            api_rd_en   <= 1'b0;
            done        <= 1'b0;
            // Read data returns one cycle after the read, so compare against the word held then.
            cmp_pending <= api_rd_en;
            cmp_word    <= api_wr_data;
            cmp_addr    <= api_addr;
            if (cmp_pending && (api_rd_data != cmp_word) && !cmp_fail) begin
                cmp_fail      <= 1'b1;
                cmp_fail_addr <= cmp_addr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cmp_fail      <= 1'b0;
                        cmp_fail_addr <= '0;
                        if (cfg_legal) begin
                            state       <= RUN;
                            d_q         <= d_sel;
                            cmp_mode_q  <= compare_mode;
                            addr_ptr    <= dest_base_addr;
                            beats_left  <= BEAT_W'(num_poly) * BEAT_W'(256 / COEFF_PER_CLK);
                            acc         <= '0;
                            fill        <= '0;
                            tail        <= 1'b0;
                            coeff_ready <= 1'b1;
                            cfg_err     <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    acc         <= acc_next;
                    fill        <= fill_next;
                    beats_left  <= beats_next;
                    coeff_ready <= (state == RUN) && (beats_next != '0) && room_next;
                    if (pop) begin
                        api_wr_en   <= !cmp_mode_q;
                        api_rd_en   <= cmp_mode_q;
                        api_addr    <= addr_ptr;
                        api_wr_data <= acc[DATA_WIDTH-1:0];
                        addr_ptr    <= addr_ptr + ADDR_W'(1);
                    end
                    if (state == RUN) begin
                        if (accept && beats_left == BEAT_W'(1))
                            state <= DRAIN;
                    end else if (fill == '0) begin
                        // Compare mode waits one extra cycle so the last read is evaluated.
                        if (!cmp_mode_q || tail) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            tail <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
